uart_rx_deframer: RTL
=====================

// Module: uart_rx_deframer
// PURPOSE
//  UART receive front end: oversampling deserializer that feeds the receive error checker.
//  - Synchronizes rx_serial.
//  - Detects the start edge and majority-votes each bit at mid-bit.
//  - Shifts in 8 data bits LSB-first, plus an optional parity bit and the stop bit.
//  - Presents raw_data, start_bit, parity_bit, stop_bit and recieved_flag to the error checker.
// PARAMETERS
//  OVERSAMPLE  16  baud_tick pulses per bit period; even, >=8
//  SYNC_STAGES  2  flip-flops in the rx_serial synchronizer; >=2
// PORTS
//  clock          in   1  single design clock
//  reset_n        in   1  synchronous, active-low reset
//  baud_tick      in   1  one-clock enable pulse at OVERSAMPLE x baud rate
//  rx_serial      in   1  asynchronous serial line; idle high
//  parity_type    in   2  01 ODD, 10 EVEN, 00/11 no parity
//  raw_data       out  8  received data byte
//  start_bit      out  1  voted start-bit value (0 = legal)
//  parity_bit     out  1  voted parity bit; forced 1 when no parity
//  stop_bit       out  1  voted stop-bit value (1 = legal)
//  recieved_flag  out  1  frame complete; outputs valid while high
//  active_flag    out  1  frame reception in progress
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge, any state):
//    - state=IDLE; counters and shift register cleared; synchronizer preset to 1.
//    - raw_data=0, start_bit=0, parity_bit=1, stop_bit=1, recieved_flag=0, active_flag=0.
//  - States: IDLE -> START -> DATA -> PARITY (skipped if no parity) -> STOP -> IDLE.
//  - IDLE: a 1->0 transition on synchronized rx is checked every clock, not gated by baud_tick.
//    - On detection: tick_cnt=0, bit_cnt=0, parity_type captured for the whole frame.
//    - active_flag=1 and recieved_flag=0 on that same clock; state -> START.
//  - Bit timing: tick_cnt advances only on baud_tick.
//    - Votes are taken at tick_cnt = H-1, H, H+1, with H=OVERSAMPLE/2.
//    - Bit value = majority of the 3 votes, resolved on the H+1 tick.
//    - On the tick with tick_cnt=OVERSAMPLE-1: tick_cnt wraps to 0 and the next state is entered.
//  - START: the voted value is recorded and the frame continues even if it is 1.
//    - A false or short start is reported via start_bit, not aborted.
//  - DATA: 8 bits, LSB first, shifted into an internal register; bit_cnt 0..7.
//    - Leave after bit_cnt=7 completes.
//  - PARITY: one voted bit, entered only if the captured type is ODD or EVEN.
//  - STOP: on the H+1 tick (mid stop bit):
//    - Shadow register -> raw_data; start, parity and stop values -> their output ports.
//    - recieved_flag=1 and active_flag=0 on the next clock; state -> IDLE immediately.
//    - Back-to-back frames with zero idle are therefore accepted.
//  - Output hold: outputs and recieved_flag stay stable until the next start edge or reset.
//    - Latency: recieved_flag rises exactly 1 clock after the baud_tick that resolves the stop vote.
//  - Stop = 0 (framing error or break): stop_bit=0 is reported.
//    - No new start is detected until rx has been sampled high, because edge detection needs a prior 1.
//  - parity_type changes mid-frame have no effect until the next start edge.
//  - baud_tick coincident with start-edge detection: the tick is not counted.
//  - No parity computation or checking here; that is done downstream.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    - localparams PAR_NOPARITY00=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NOPARITY11=2'b11;
//    - RX state encodings IDLE/START/DATA/PARITY/STOP;
//    - DATA_BITS=8.
//  - Sub-module uart_rx_sampler contains:
//    - synchronizer, edge detector, tick_cnt, 3-sample majority voter;
//    - outputs: start_edge, bit_valid (1 clock), bit_value, bit_end.
//  - Top level contains the FSM, bit_cnt, shift register and output registers.
// TESTING
//  1. 8E1 frame, data 0xA5, parity 0, stop 1
//     -> raw_data=A5, start_bit=0, parity_bit=0, stop_bit=1, recieved_flag=1 one clock after the stop vote.
//  2. 8O1 frame 0x3C with parity 1, then immediately an 8N1 frame 0x00 (type 00) with zero idle
//     -> first: 3C/parity 1; second: 00 with parity_bit=1; both flags seen.
//  3. Stop bit driven 0 on an 8N1 frame 0x81
//     -> stop_bit=0, raw_data=81; line held low afterwards -> no new frame until rx returns high.
//  4. rx low for exactly 1 tick at the H tick of data bit 3 of 0xFF
//     -> majority rejects it; raw_data=FF.
//  5. Start pulse only 4 ticks low, then high
//     -> start_bit=1 reported; frame completes; recieved_flag=1.
//  6. reset_n=0 for 1 clock during DATA bit 5
//     -> next clock all outputs at reset values, active_flag=0; a following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity-type codes,
// receive FSM state encoding, frame width and a 3-input majority helper.
package uart_pkg;

    localparam logic [1:0] PAR_NOPARITY00 = 2'b00;
    localparam logic [1:0] PAR_ODD        = 2'b01;
    localparam logic [1:0] PAR_EVEN       = 2'b10;
    localparam logic [1:0] PAR_NOPARITY11 = 2'b11;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic has_parity(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Bundle between the UART receive deframer and its surroundings.
// master: the deframer (consumes line/tick/config, produces frame fields).
// slave : the environment (drives line/tick/config, reads frame fields).
interface uart_rx_deframer_if;

    logic       baud_tick;
    logic       rx_serial;
    logic [1:0] parity_type;
    logic [7:0] raw_data;
    logic       start_bit;
    logic       parity_bit;
    logic       stop_bit;
    logic       recieved_flag;
    logic       active_flag;

    modport master (
        input  baud_tick,
        input  rx_serial,
        input  parity_type,
        output raw_data,
        output start_bit,
        output parity_bit,
        output stop_bit,
        output recieved_flag,
        output active_flag
    );

    modport slave (
        output baud_tick,
        output rx_serial,
        output parity_type,
        input  raw_data,
        input  start_bit,
        input  parity_bit,
        input  stop_bit,
        input  recieved_flag,
        input  active_flag
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling bit sampler: rx synchronizer, falling-edge detector,
// per-bit tick counter and 3-sample mid-bit majority voter.
// Ports: clock, reset_n (sync, active-low), baud_tick, rx_serial (async),
//   clear (restart bit timing), run (count ticks) ->
//   start_edge (1->0 on synced rx), bit_valid (vote resolved, 1 clock),
//   bit_value (voted value, valid with bit_valid), bit_end (last tick of bit).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic baud_tick,
    input  logic rx_serial,
    input  logic clear,
    input  logic run,
    output logic start_edge,
    output logic bit_valid,
    output logic bit_value,
    output logic bit_end
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] T_LO  = CW'(H - 1);
    localparam logic [CW-1:0] T_MID = CW'(H);
    localparam logic [CW-1:0] T_HI  = CW'(H + 1);
    localparam logic [CW-1:0] T_END = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
    logic                   vote0_q, vote0_d;
    logic                   vote1_q, vote1_d;
    logic                   rx_s;
    logic                   tick_en;

    always_comb begin
        rx_s       = sync_q[SYNC_STAGES-1];
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx_serial};
        prev_d     = rx_s;
        // A tick landing on the restart clock is dropped: clear wins.
        tick_en    = run & baud_tick & ~clear;
        tick_cnt_d = tick_cnt_q;
        vote0_d    = vote0_q;
        vote1_d    = vote1_q;
        if (clear) begin
            tick_cnt_d = '0;
        end else if (tick_en) begin
            tick_cnt_d = (tick_cnt_q == T_END) ? '0 : tick_cnt_q + 1'b1;
        end
        if (tick_en && tick_cnt_q == T_LO) vote0_d = rx_s;
        if (tick_en && tick_cnt_q == T_MID) vote1_d = rx_s;
    end

    // Third vote is the live sample, so the result is ready on the H+1 tick.
    assign start_edge = prev_q & ~rx_s;
    assign bit_valid  = tick_en && (tick_cnt_q == T_HI);
    assign bit_value  = maj3(vote0_q, vote1_q, rx_s);
    assign bit_end    = tick_en && (tick_cnt_q == T_END);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            tick_cnt_q <= '0;
            vote0_q    <= 1'b0;
            vote1_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            tick_cnt_q <= tick_cnt_d;
            vote0_q    <= vote0_d;
            vote1_q    <= vote1_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/data/parity/stop sequencing on top of the
// oversampling sampler; presents the raw frame fields to the error checker.
// Ports: clock, reset_n (sync, active-low), bus (uart_rx_deframer_if.master):
//   in  baud_tick, rx_serial, parity_type
//   out raw_data, start_bit, parity_bit, stop_bit, recieved_flag, active_flag
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    uart_rx_deframer_if.master    bus
);

    localparam int BCW = $clog2(DATA_BITS);

    rx_state_e            state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           ptype_q, ptype_d;
    logic                 start_val_q, start_val_d;
    logic                 par_val_q, par_val_d;
    logic [DATA_BITS-1:0] raw_data_q, raw_data_d;
    logic                 start_bit_q, start_bit_d;
    logic                 parity_bit_q, parity_bit_d;
    logic                 stop_bit_q, stop_bit_d;
    logic                 recv_q, recv_d;
    logic                 active_q, active_d;

    logic start_edge;
    logic bit_valid;
    logic bit_value;
    logic bit_end;
    logic clear;
    logic run;

    assign clear = (state_q == IDLE) & start_edge;
    assign run   = (state_q != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_tick  (bus.baud_tick),
        .rx_serial  (bus.rx_serial),
        .clear      (clear),
        .run        (run),
        .start_edge (start_edge),
        .bit_valid  (bit_valid),
        .bit_value  (bit_value),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptype_d      = ptype_q;
        start_val_d  = start_val_q;
        par_val_d    = par_val_q;
        raw_data_d   = raw_data_q;
        start_bit_d  = start_bit_q;
        parity_bit_d = parity_bit_q;
        stop_bit_d   = stop_bit_q;
        recv_d       = recv_q;
        active_d     = active_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    ptype_d   = bus.parity_type;
                    // Preset so a no-parity frame reports parity_bit=1.
                    par_val_d = 1'b1;
                    active_d  = 1'b1;
                    recv_d    = 1'b0;
                end
            end
            START: begin
                if (bit_valid) start_val_d = bit_value;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_valid) shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = has_parity(ptype_q) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_valid) par_val_d = bit_value;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Finish at mid stop bit so a zero-idle next start is caught.
                if (bit_valid) begin
                    raw_data_d   = shift_q;
                    start_bit_d  = start_val_q;
                    parity_bit_d = par_val_q;
                    stop_bit_d   = bit_value;
                    recv_d       = 1'b1;
                    active_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptype_q      <= PAR_NOPARITY00;
            start_val_q  <= 1'b0;
            par_val_q    <= 1'b1;
            raw_data_q   <= '0;
            start_bit_q  <= 1'b0;
            parity_bit_q <= 1'b1;
            stop_bit_q   <= 1'b1;
            recv_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptype_q      <= ptype_d;
            start_val_q  <= start_val_d;
            par_val_q    <= par_val_d;
            raw_data_q   <= raw_data_d;
            start_bit_q  <= start_bit_d;
            parity_bit_q <= parity_bit_d;
            stop_bit_q   <= stop_bit_d;
            recv_q       <= recv_d;
            active_q     <= active_d;
        end
    end

    assign bus.raw_data      = raw_data_q;
    assign bus.start_bit     = start_bit_q;
    assign bus.parity_bit    = parity_bit_q;
    assign bus.stop_bit      = stop_bit_q;
    assign bus.recieved_flag = recv_q;
    assign bus.active_flag   = active_q;

endmodule
